// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bits needed to index 'value' distinct codes (at least 1).
  function automatic int clog2_f(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_gen_req_filter.sv
// Glitch filter for the reset request: req_out rises once req_in has been
// high for FILTER_CYCLES consecutive edges and falls with req_in.
module req_filter
  import reset_seq_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n_in,
  input  logic req_in,
  output logic req_out
);

  localparam int FILT_W = clog2_f(FILTER_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILTER_CYCLES);

  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("req_filter: FILTER_CYCLES must be at least 1");
  end

  logic [FILT_W-1:0] run_cnt;

  // Count consecutive high samples, saturating so a long request never wraps.
  always_ff @(posedge clk) begin
    // NOTE: every flop update uses <= so all registers see pre-edge values.
    if (!reset_n_in) begin
      run_cnt <= '0;
      req_out <= 1'b0;
    end else if (!req_in) begin
      run_cnt <= '0;
      req_out <= 1'b0;
    end else begin
      if (run_cnt != FILT_MAX) run_cnt <= run_cnt + 1'b1;
      req_out <= (run_cnt >= FILT_LAST);
    end
  end

endmodule

// File: rtl/reset_seq_gen.sv
// Staggered reset release: holds all channels in reset, then releases
// channel 0 after HOLD_CYCLES enabled edges and each following channel
// STAGGER_CYCLES enabled edges later. A filtered request restarts it.
module reset_seq_gen
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int FILTER_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              reset_n_in,
  input  logic              clk_enable,
  input  logic              req_in,
  output logic [NUM_CH-1:0] reset_out,
  output logic              done
);

  localparam int CNT_W = clog2_f(max_f(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_CH-1:0] LAST_ONLY    = NUM_CH'(1) << (NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("reset_seq_gen: NUM_CH must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_seq_gen: HOLD_CYCLES must be at least 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("reset_seq_gen: STAGGER_CYCLES must be at least 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_filt;

  req_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_req_filter (
    .clk       (clk),
    .reset_n_in(reset_n_in),
    .req_in    (req_in),
    .req_out   (req_filt)
  );

  // Sequencer FSM; channels release low-to-high by shifting zeros in from bit 0.
  always_ff @(posedge clk) begin
    if (!reset_n_in) begin
      state     <= ASSERT;
      cnt       <= '0;
      reset_out <= '1;
      done      <= 1'b0;
    end else if (req_filt) begin
      state     <= ASSERT;
      cnt       <= '0;
      reset_out <= '1;
      done      <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            reset_out <= reset_out << 1;
            if (NUM_CH == 1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == STAGGER_LAST) begin
            cnt       <= '0;
            reset_out <= reset_out << 1;
            if (reset_out == LAST_ONLY) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          state     <= ASSERT;
          cnt       <= '0;
          reset_out <= '1;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_seq_gen.md
RESET_SEQ_GEN -- requirements
Module: reset_seq_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sequenced reset outputs, legal range 1..16.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: enabled cycles all outputs stay asserted before the first release, minimum 1.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 8: enabled cycles between successive channel releases, minimum 1.
REQ-004 SHALL have parameter FILTER_CYCLES, default 4: consecutive clk cycles req_in must be high to count as a request, minimum 1.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n_in, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port clk_enable, input, 1: qualifies the hold and stagger counting only.
REQ-008 SHALL have port req_in, input, 1: active-high reset request, already synchronous to clk.
REQ-009 SHALL have port reset_out, output, NUM_CH: active-high per-channel resets, registered.
REQ-010 SHALL have port done, output, 1: high when every channel is released, registered.

Function
REQ-011 SHALL implement an FSM with states ASSERT, RELEASE and DONE.
REQ-012 In ASSERT, the hold counter SHALL increment on each edge with clk_enable=1 and SHALL hold otherwise.
REQ-013 On the enabled edge where the hold count equals HOLD_CYCLES-1, the block SHALL clear reset_out[0], clear the counter, and enter RELEASE (or DONE with done=1 when NUM_CH=1).
REQ-014 In RELEASE, reset_out[k] SHALL clear exactly STAGGER_CYCLES enabled edges after reset_out[k-1] cleared.
REQ-015 Once reset_n_in is high and clk_enable is held at 1, reset_out[k] SHALL fall after HOLD_CYCLES + k*STAGGER_CYCLES edges.
REQ-016 done SHALL rise on the same edge that reset_out[NUM_CH-1] clears, and the FSM SHALL enter DONE on that edge.
REQ-017 In DONE, outputs SHALL be stable (reset_out all 0, done 1) until a filtered request or reset arrives.
REQ-018 The filter counter SHALL count every clk edge with req_in=1, regardless of clk_enable, and SHALL clear on any edge with req_in=0.
REQ-019 The filtered request SHALL assert on the edge where the filter count reaches FILTER_CYCLES, and SHALL remain asserted while req_in stays high.
REQ-020 While the filtered request is asserted, on the next edge and from any state, the block SHALL:
- set reset_out to all 1s;
- clear done and the hold/stagger counter;
- enter ASSERT.
REQ-021 While the filtered request remains asserted, the counter SHALL hold at 0, and sequencing SHALL restart on the first edge after it drops.
REQ-022 Release order SHALL always be channel 0 up to NUM_CH-1, and a released channel SHALL never re-assert except via REQ-020 or reset.
REQ-023 Priority SHALL be reset_n_in, then the filtered request, then clk_enable-qualified counting.
REQ-024 The counter width SHALL be ceil(log2(max(HOLD_CYCLES, STAGGER_CYCLES)+1)), and the counter SHALL never wrap.

Reset
REQ-025 On an edge with reset_n_in=0, the block SHALL:
- set reset_out to all 1s and done to 0;
- set the FSM to ASSERT;
- clear the hold/stagger counter, the filter counter and the filtered-request flag.
REQ-026 Reset asserted mid-RELEASE SHALL re-assert all channels on that edge, and the full sequence SHALL restart after release.
REQ-027 Outputs SHALL be glitch-free: every output SHALL be driven directly from a flop.

Structure
REQ-028 Shared package reset_seq_pkg SHALL hold:
- the FSM state encodings (ASSERT=2'd0, RELEASE=2'd1, DONE=2'd2);
- the clog2/max width helper functions.
REQ-029 Request filtering SHALL be a sub-module named req_filter, parameter FILTER_CYCLES, ports clk, reset_n_in, req_in, req_out.
REQ-030 Illegal parameter values SHALL stop elaboration with an error.

Verification
REQ-031 Defaults with clk_enable=1: release reset_n_in -> reset_out[0..3] fall at edges 16, 24, 32, 40, and done rises at edge 40.
REQ-032 clk_enable high only on every other edge -> all release times double (32, 48, 64, 80), and done rises at edge 80.
REQ-033 req_in high for 3 edges then low, while in DONE -> no change; req_in high for 4 edges -> reset_out=4'b1111 and done=0 on the following edge.
REQ-034 Filtered request asserted at edge 28 (reset_out=4'b1100), held 10 edges, then dropped -> all channels assert, then the sequence restarts 16/8/8/8 from the edge after it drops.
REQ-035 reset_n_in pulsed low for 1 edge at edge 30 -> reset_out=4'b1111 and done=0 at that edge, then full sequence replays.
REQ-036 NUM_CH=1, HOLD_CYCLES=1 -> reset_out and done change on the first enabled edge after reset.
